rgb2gray_engine: RTL
====================

# rgb2gray_engine

Streaming converter that reads the 320x240 RGB444 frame from the colour BRAM, converts each pixel to 8-bit luminance, and writes it to the gray BRAM at the same address. It sits between the colour BRAM and the gray BRAM. The AXI-lite slave starts it with a single pulse, and it reports completion through a done level that the slave polls before it starts the Sobel stage. Throughput is one pixel per clock, so a frame converts in NPIX+3 cycles.

## Interface

Parameters:
- NPIX, 76800, number of pixels per frame (320x240)
- AW, 17, BRAM address width
- CW, 12, colour pixel width (R[11:8], G[7:4], B[3:0])
- GW, 8, gray pixel width

Ports:
- i_CLK  in  1  single clock, rising edge
- i_RST  in  1  synchronous, active-high reset
- i_START  in  1  one-cycle start pulse from the AXI slave
- i_GRANT  in  1  1 = this stage owns both BRAM ports (decoded from ACCESS_CONTROL)
- o_BUSY  out  1  high from accepted start until the last write
- o_DONE  out  1  completion level, cleared by the next accepted start
- o_COLOR_RDEN  out  1  colour BRAM read enable
- o_COLOR_RDADDR  out  AW  colour BRAM read address
- i_COLOR_RDDATA  in  CW  colour BRAM data, valid one cycle after RDEN
- o_GRAY_WREN  out  1  gray BRAM write enable
- o_GRAY_WRADDR  out  AW  gray BRAM write address
- o_GRAY_WRDATA  out  GW  gray BRAM write data

## Operation

- **FSM states:** IDLE, RUN, DRAIN, DONE.
- **IDLE → RUN:** on i_START=1 and i_GRANT=1. The read address counter is cleared to 0.
- **DONE → RUN:** same condition; o_DONE is cleared on the same edge.
- **Start otherwise ignored:** i_START in RUN or DRAIN is ignored. i_START with i_GRANT=0 is ignored in every state.
- **RUN, issuing reads:** each cycle with i_GRANT=1 the block drives o_COLOR_RDEN=1 with the current address, then increments the address.
- **RUN, grant withdrawn:** while i_GRANT=0, o_COLOR_RDEN=0 and the address holds. Reads already in flight still complete and write.
- **RUN → DRAIN:** after the read of address NPIX-1 is issued.
- **DRAIN → DONE:** after the write of address NPIX-1.
- **DONE:** holds o_DONE=1 until the next accepted start.
- **Pipeline stage 1:** RDEN and address are registered together with a valid bit.
- **Pipeline stage 2:** the valid bit and address are delayed one cycle to align with i_COLOR_RDDATA.
- **Pipeline stage 3:** gray is computed and registered, then driven as WREN / WRADDR / WRDATA.
- **Expansion:** each 4-bit channel becomes 8 bits by nibble replication, R8={R4,R4}, and likewise for G and B.
- **Gray formula:** gray = (77*R8 + 150*G8 + 29*B8) >> 8.
- **Intermediate width:** 16 bits unsigned. The maximum is 65280, so the result never exceeds 255 and no saturation is needed.
- **Write address:** always equals the read address it was derived from; no row/column arithmetic is applied.
- **Counter wrap:** the address counter never exceeds NPIX-1 and does not wrap into a second frame.
- **Reset values:** every output is 0, the FSM is in IDLE, the counter is 0 and the pipeline valid bits are 0.
- **Reset mid-frame:** no write is issued on the cycle after reset. Partially written gray data is left as is.

## Timing

- **Start (cycle 0):** i_START sampled high with grant.
- **Cycle 1:** o_BUSY=1, o_COLOR_RDEN=1, o_COLOR_RDADDR=0.
- **Read data:** the data for the read issued at cycle k is on i_COLOR_RDDATA at cycle k+1.
- **Write:** o_GRAY_WREN=1 with the matching address at cycle k+2.
- **Uninterrupted frame:**
  - reads at cycles 1..NPIX;
  - writes at cycles 3..NPIX+2;
  - o_BUSY falls and o_DONE rises at cycle NPIX+3.
- **Grant stalls:** each cycle of i_GRANT=0 during RUN adds exactly one cycle to the total latency.
- **Simultaneous start and grant drop:** i_START=1 with i_GRANT=0 on the same cycle is not accepted.
- **Simultaneous reset and start:** i_RST=1 together with i_START=1 leaves the block in IDLE, with reset taking priority.

## Test plan

- **Pixel values:** write colour pixels 0xFFF, 0x000, 0xF00 and 0x0F0 at addresses 0..3 with NPIX=4, then pulse start. Required:
  - gray BRAM holds 255, 0, 76 and 149;
  - o_DONE rises at cycle 7.
- **Full frame:** 76800 random pixels (seed = address), start with grant held high. Required:
  - every gray word matches the reference formula;
  - exactly 76800 WREN cycles;
  - o_DONE at cycle 76803.
- **Grant drop:** drop i_GRANT for 10 cycles at pixel 100. Required:
  - no RDEN during the gap;
  - addresses continue at 101 with no duplicates and no gaps;
  - o_DONE at cycle NPIX+13.
- **Ignored starts:** pulse i_START mid-frame, and separately pulse it with i_GRANT=0. Required: the counter is unaffected and no restart occurs.
- **Reset mid-frame:** assert i_RST at pixel 500. Required:
  - all outputs are 0 on the next cycle;
  - a new start converts from address 0.
- **Back-to-back frames:** pulse i_START while o_DONE=1. Required:
  - o_DONE clears on the next cycle;
  - a second full frame converts correctly.

Source files
------------

// File: rtl/rgb2gray_engine.sv
// rgb2gray_engine: streams an RGB444 frame from the colour BRAM through a
// three-stage pipeline, converts each pixel to 8-bit luminance and writes it to
// the gray BRAM at the same address. One pixel per clock when granted.
module rgb2gray_engine #(
   parameter int unsigned NPIX = 76800,
   parameter int unsigned AW   = 17,
   parameter int unsigned CW   = 12,
   parameter int unsigned GW   = 8
) (
   input  logic          i_CLK,
   input  logic          i_RST,
   input  logic          i_START,
   input  logic          i_GRANT,
   output logic          o_BUSY,
   output logic          o_DONE,
   output logic          o_COLOR_RDEN,
   output logic [AW-1:0] o_COLOR_RDADDR,
   input  logic [CW-1:0] i_COLOR_RDDATA,
   output logic          o_GRAY_WREN,
   output logic [AW-1:0] o_GRAY_WRADDR,
   output logic [GW-1:0] o_GRAY_WRDATA
);

   typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

   localparam logic [AW-1:0] LastAddr = AW'(NPIX - 1);

   state_e        state_q, state_d;

   // Next address to read; never advances past LastAddr.
   logic [AW-1:0] cnt_q, cnt_d;

   // Stage 1: registered read request.
   logic          rden_q, rden_d;
   logic [AW-1:0] rdaddr_q, rdaddr_d;

   // Stage 2: request delayed to line up with the BRAM read data.
   logic          v2_q, v2_d;
   logic [AW-1:0] a2_q, a2_d;

   // Stage 3: registered write.
   logic          wren_q, wren_d;
   logic [AW-1:0] wraddr_q, wraddr_d;
   logic [GW-1:0] wrdata_q, wrdata_d;

   logic          accept;
   logic          issue;
   logic [AW-1:0] issue_addr;
   logic          last_issue;
   logic          last_write;

   logic [3:0]    r4, g4, b4;
   logic [7:0]    r8, g8, b8;
   logic [15:0]   luma_sum;
   logic [GW-1:0] gray;

   // Decode start acceptance and read issue for this cycle.
   always_comb begin
      accept     = i_START && i_GRANT && ((state_q == StIdle) || (state_q == StDone));
      // The first read goes out on the same edge the start is accepted.
      issue      = accept || ((state_q == StRun) && i_GRANT);
      issue_addr = accept ? '0 : cnt_q;
      last_issue = issue && (issue_addr == LastAddr);
      last_write = wren_q && (wraddr_q == LastAddr);
   end

   // FSM state register.
   always_ff @(posedge i_CLK) begin
      if (i_RST) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next-state logic.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle, StDone: begin
            if (accept) begin
               state_d = last_issue ? StDrain : StRun;
            end
         end
         StRun: begin
            if (last_issue) begin
               state_d = StDrain;
            end
         end
         StDrain: begin
            if (last_write) begin
               state_d = StDone;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // FSM outputs.
   always_comb begin
      o_BUSY = (state_q == StRun) || (state_q == StDrain);
      o_DONE = (state_q == StDone);
   end

   // Luminance: nibbles are widened by replication, weights sum to 256.
   always_comb begin
      r4       = i_COLOR_RDDATA[11:8];
      g4       = i_COLOR_RDDATA[7:4];
      b4       = i_COLOR_RDDATA[3:0];
      r8       = {r4, r4};
      g8       = {g4, g4};
      b8       = {b4, b4};
      luma_sum = 16'd77 * 16'(r8) + 16'd150 * 16'(g8) + 16'd29 * 16'(b8);
      gray     = GW'(luma_sum >> 8);
   end

   // Pipeline and address counter next-state.
   always_comb begin
      cnt_d    = cnt_q;
      rden_d   = issue;
      rdaddr_d = rdaddr_q;
      if (issue) begin
         rdaddr_d = issue_addr;
         cnt_d    = last_issue ? issue_addr : issue_addr + AW'(1);
      end

      v2_d     = rden_q;
      a2_d     = rdaddr_q;

      wren_d   = v2_q;
      wraddr_d = wraddr_q;
      wrdata_d = wrdata_q;
      if (v2_q) begin
         wraddr_d = a2_q;
         wrdata_d = gray;
      end
   end

   // Pipeline and counter registers; reset kills any write in flight.
   always_ff @(posedge i_CLK) begin
      if (i_RST) begin
         cnt_q    <= '0;
         rden_q   <= 1'b0;
         rdaddr_q <= '0;
         v2_q     <= 1'b0;
         a2_q     <= '0;
         wren_q   <= 1'b0;
         wraddr_q <= '0;
         wrdata_q <= '0;
      end else begin
         cnt_q    <= cnt_d;
         rden_q   <= rden_d;
         rdaddr_q <= rdaddr_d;
         v2_q     <= v2_d;
         a2_q     <= a2_d;
         wren_q   <= wren_d;
         wraddr_q <= wraddr_d;
         wrdata_q <= wrdata_d;
      end
   end

   // Port drive.
   always_comb begin
      o_COLOR_RDEN   = rden_q;
      o_COLOR_RDADDR = rdaddr_q;
      o_GRAY_WREN    = wren_q;
      o_GRAY_WRADDR  = wraddr_q;
      o_GRAY_WRDATA  = wrdata_q;
   end

endmodule
